dec_4_92_stream: RTL and testbench
==================================

// Module: dec_4_92_stream
// PURPOSE
//  Decoder layer directly downstream of the 92->4 encoder. It expands the 4-element latent vector
//  to 92 outputs: y[j] = act(b[j] + sum_k x[k]*w[j][k]).
//  One output element is computed per cycle by a 4-lane MAC. Results stream out on a
//  valid/ready port and are also collected into a full output vector.
//  x and in_valid connect straight to the encoder's y and done_all.
// PARAMETERS
//  BITSIZE   16  element width, signed two's-complement fixed point
//  FRAC_BITS 8   fractional bits (Q8.8 at defaults)
//  IN_SIZE   4   latent width (the encoder's OUT_SIZE)
//  OUT_SIZE  92  reconstructed width
//  RELU      1   1: clamp negative results to 0; 0: identity
// PORTS
//  clk       in   1                        rising-edge clock
//  reset     in   1                        asynchronous, active-low (0 = in reset)
//  in_valid  in   1                        level; the encoder's done_all
//  x         in   BITSIZE*IN_SIZE          latent vector; element k at [k*BITSIZE +: BITSIZE]
//  w         in   BITSIZE*OUT_SIZE*IN_SIZE w[j][k] at [(j*IN_SIZE+k)*BITSIZE +: BITSIZE]
//  b         in   BITSIZE*OUT_SIZE         bias; b[j] at [j*BITSIZE +: BITSIZE]
//  out_data  out  BITSIZE                  streamed element
//  out_idx   out  $clog2(OUT_SIZE)         index j of out_data
//  out_valid out  1                        stream valid
//  out_ready in   1                        stream ready from consumer
//  y         out  BITSIZE*OUT_SIZE         collected outputs; y[j] at [j*BITSIZE +: BITSIZE]
//  done_all  out  1                        high while all OUT_SIZE elements have been delivered
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; out_data, out_idx, out_valid, y, done_all, compute index and x_reg all 0
//   - in_valid_q=0, so in_valid high at reset release counts as a rising edge
//  in_valid_q: registers in_valid every cycle. start = in_valid & ~in_valid_q.
//  IDLE:
//   - on start, latch x into x_reg, set idx=0, go to RUN
//   - x is sampled only on this edge
//  RUN, per cycle, when idx<OUT_SIZE and (!out_valid || out_ready):
//   - p_k = ($signed(x_reg[k]) * $signed(w[idx][k])) >>> FRAC_BITS, 2*BITSIZE signed,
//     truncated to BITSIZE (no saturation)
//   - s = b[idx] + p_0 + ... + p_(IN_SIZE-1), computed in BITSIZE bits with modulo wrap
//   - if RELU and s[MSB]=1, s=0
//   - register s into out_data and y[idx]; out_idx<=idx; out_valid<=1; idx<=idx+1
//  Stream handshake:
//   - a transfer occurs when out_valid & out_ready
//   - out_data and out_idx hold while out_valid & ~out_ready
//   - out_valid drops after a transfer if no new element is loaded that cycle
//   - no element is skipped or duplicated
//  RUN -> DONE: when idx==OUT_SIZE and the last element transfers (or out_valid=0).
//  DONE:
//   - done_all=1, y stable
//   - when in_valid==0, go to IDLE and set done_all=0; y retains its values
//  Latency with out_ready=1 (start sampled at edge 0):
//   - element j valid after edge j+2
//   - done_all=1 after edge OUT_SIZE+2
//   - throughput 1 element/cycle
//  in_valid edges in RUN or DONE are ignored: no re-capture, no restart.
//  A new inference requires in_valid to go low then high again.
//  in_valid falling in RUN does not abort the run; DONE is then exited after one cycle.
//  Reset mid-RUN discards partial results: y and the stream clear immediately.
// TESTING
//  1. x=4x0x0100, all w=0x0080, b=0, out_ready=1 -> 92 elements 0x0200, idx 0..91 consecutive;
//     done_all after edge 94; y all 0x0200
//  2. w=0, all b=0xFF00: RELU=1 -> every out_data=0x0000; RELU=0 -> every out_data=0xFF00
//  3. Case 1 with out_ready toggling 1,0,1,0... -> data/idx held while stalled;
//     exactly 92 transfers, idx 0..91 in order
//  4. x=4x0x7F00, w=0x7F00, b=0 -> each p_k=0x0100 (truncated); out=0x0400
//  5. reset=0 at element 10 -> out_valid, done_all, y=0 immediately;
//     release with in_valid=1 -> full run from idx 0
//  6. in_valid held high after DONE -> no second run; drop low then raise with a new x ->
//     second run uses the new x

Source files
------------

// File: rtl/dec_4_92_stream.sv
// -----------------------------------------------------------------------------
// dec_4_92_stream
// Decoder layer that sits directly behind the 92->4 encoder. It expands the
// 4-element latent vector into 92 outputs, y[j] = act(b[j] + sum_k x[k]*w[j][k]).
// A 4-lane MAC produces one output element per cycle. Each result is streamed
// out on a valid/ready port and is also written into a full output vector.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = in reset)
//   in_valid   level start request (the encoder's done_all)
//   x          latent vector, element k at [k*BITSIZE +: BITSIZE]
//   w          weights, w[j][k] at [(j*IN_SIZE+k)*BITSIZE +: BITSIZE]
//   b          biases, b[j] at [j*BITSIZE +: BITSIZE]
//   out_data   streamed result element
//   out_idx    index j of out_data
//   out_valid  stream valid
//   out_ready  stream ready from the consumer
//   y          collected outputs, y[j] at [j*BITSIZE +: BITSIZE]
//   done_all   high while every element has been delivered
// -----------------------------------------------------------------------------
module dec_4_92_stream #(
    parameter int BITSIZE   = 16,
    parameter int FRAC_BITS = 8,
    parameter int IN_SIZE   = 4,
    parameter int OUT_SIZE  = 92,
    parameter int RELU      = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [BITSIZE*IN_SIZE-1:0]          x,
    input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
    input  logic [BITSIZE*OUT_SIZE-1:0]         b,
    output logic [BITSIZE-1:0]                  out_data,
    output logic [$clog2(OUT_SIZE)-1:0]         out_idx,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BITSIZE*OUT_SIZE-1:0]         y,
    output logic                                done_all
);

    localparam int IW = $clog2(OUT_SIZE);
    // The compute index must be able to hold OUT_SIZE itself ("all issued").
    localparam int CW = $clog2(OUT_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(OUT_SIZE);

    // LOAD is a one-cycle arming step between capturing x and the first MAC,
    // which places element j on the stream two edges after start plus j.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       in_valid_q;
    logic                       start;
    logic [BITSIZE*IN_SIZE-1:0] x_reg;
    logic [CW-1:0]              idx;
    logic [CW-1:0]              sel;
    logic                       load;
    logic                       slot_free;
    logic signed [2*BITSIZE-1:0] prod;
    logic [BITSIZE-1:0]         p_trunc;
    logic [BITSIZE-1:0]         acc;
    logic [BITSIZE-1:0]         mac_out;

    assign start     = in_valid & ~in_valid_q;
    // The output register may take a new element when empty or being drained.
    assign slot_free = ~out_valid | out_ready;
    assign load      = (state == RUN) && (idx < LAST) && slot_free;
    assign done_all  = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Extra in_valid edges during LOAD/RUN/DONE are ignored;
    // leaving DONE needs in_valid low, so a new run needs a fresh rising edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if ((idx == LAST) && slot_free) state_next = DONE;
            DONE: if (!in_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // 4-lane MAC for element sel. Each product is rescaled by FRAC_BITS and
    // truncated to BITSIZE, and the sum wraps modulo 2^BITSIZE. The index is
    // clamped once every element has been issued so the weight select stays
    // in range.
    always_comb begin
        sel     = (idx < LAST) ? idx : '0;
        acc     = b[int'(sel)*BITSIZE +: BITSIZE];
        prod    = '0;
        p_trunc = '0;
        for (int k = 0; k < IN_SIZE; k++) begin
            prod    = $signed(x_reg[k*BITSIZE +: BITSIZE]) *
                      $signed(w[(int'(sel)*IN_SIZE + k)*BITSIZE +: BITSIZE]);
            p_trunc = BITSIZE'(prod >>> FRAC_BITS);
            acc     = acc + p_trunc;
        end
        mac_out = acc;
        if ((RELU != 0) && acc[BITSIZE-1]) begin
            mac_out = '0;
        end
    end

    // Datapath: edge detect, latent capture, compute index, stream register
    // and collected output vector. A stalled element holds until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_valid_q <= 1'b0;
            x_reg      <= '0;
            idx        <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            out_valid  <= 1'b0;
            y          <= '0;
        end else begin
            in_valid_q <= in_valid;
            if ((state == IDLE) && start) begin
                x_reg <= x;
                idx   <= '0;
            end
            if (load) begin
                out_data                           <= mac_out;
                out_idx                            <= idx[IW-1:0];
                out_valid                          <= 1'b1;
                y[int'(sel)*BITSIZE +: BITSIZE]    <= mac_out;
                idx                                <= idx + CW'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dec_4_92_stream.sv
// -----------------------------------------------------------------------------
// tb_dec_4_92_stream
// Self-checking bench for dec_4_92_stream. Two instances share all inputs:
// dut uses the ReLU activation and dut_lin the identity activation.
// Expected values come from a behavioural model of the layer equation.
// -----------------------------------------------------------------------------
module tb_dec_4_92_stream;

    localparam int BS = 16;
    localparam int IS = 4;
    localparam int OS = 92;
    localparam int IW = $clog2(OS);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              out_ready;
    logic [BS*IS-1:0]  x;
    logic [BS*OS*IS-1:0] w;
    logic [BS*OS-1:0]  b;
    logic [BS-1:0]     out_data, out_data1;
    logic [IW-1:0]     out_idx, out_idx1;
    logic              out_valid, out_valid1;
    logic [BS*OS-1:0]  y, y1;
    logic              done_all, done_all1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] x_arr [IS];
    logic [15:0] w_arr [OS][IS];
    logic [15:0] b_arr [OS];

    logic [15:0] got_data [$];
    logic [15:0] got_data1 [$];
    int          got_idx [$];
    int          first_valid;
    int          done_cyc;
    int          hold_errs;

    dec_4_92_stream #(.BITSIZE(16), .FRAC_BITS(8), .IN_SIZE(4), .OUT_SIZE(92), .RELU(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .w(w), .b(b),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .done_all(done_all)
    );

    dec_4_92_stream #(.BITSIZE(16), .FRAC_BITS(8), .IN_SIZE(4), .OUT_SIZE(92), .RELU(0)) dut_lin (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .w(w), .b(b),
        .out_data(out_data1), .out_idx(out_idx1), .out_valid(out_valid1),
        .out_ready(out_ready), .y(y1), .done_all(done_all1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: y[j] = act(b[j] + sum_k trunc16((x[k]*w[j][k]) >>> 8)), mod 2^16.
    function automatic logic [15:0] model(int j, bit relu);
        logic [15:0] s;
        int          p;
        s = b_arr[j];
        for (int k = 0; k < IS; k++) begin
            p = int'($signed(x_arr[k])) * int'($signed(w_arr[j][k]));
            s = s + 16'(p >>> 8);
        end
        if (relu && s[15]) s = 16'h0000;
        return s;
    endfunction

    task automatic pack_inputs();
        for (int k = 0; k < IS; k++) x[k*BS +: BS] = x_arr[k];
        for (int j = 0; j < OS; j++) begin
            b[j*BS +: BS] = b_arr[j];
            for (int k = 0; k < IS; k++) w[(j*IS+k)*BS +: BS] = w_arr[j][k];
        end
    endtask

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int k = 0; k < IS; k++) x_arr[k] = xv;
        for (int j = 0; j < OS; j++) begin
            b_arr[j] = bv;
            for (int k = 0; k < IS; k++) w_arr[j][k] = wv;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < IS; k++) x_arr[k] = 16'($urandom);
        for (int j = 0; j < OS; j++) begin
            b_arr[j] = 16'($urandom);
            for (int k = 0; k < IS; k++) w_arr[j][k] = 16'($urandom);
        end
    endtask

    // Raises in_valid at a negedge (the following posedge is edge 0) and records
    // every stream transfer until done_all is seen or the budget runs out.
    // ready_mode: 0 always ready, 1 toggling 1,0,1,..., 2 random.
    task automatic run_stream(input int ready_mode, input bit drop_first, input int budget);
        bit          prev_stall;
        logic [15:0] held_d;
        logic [IW-1:0] held_i;
        if (drop_first) begin
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        pack_inputs();
        got_data.delete();
        got_data1.delete();
        got_idx.delete();
        first_valid = -1;
        done_cyc    = -1;
        hold_errs   = 0;
        prev_stall  = 1'b0;
        held_d      = '0;
        held_i      = '0;
        in_valid    = 1'b1;
        for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (prev_stall && (!out_valid || out_data !== held_d || out_idx !== held_i))
                hold_errs++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done_all) done_cyc = cyc;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_data1.push_back(out_data1);
                got_idx.push_back(int'(out_idx));
            end
            prev_stall = out_valid && !out_ready;
            held_d     = out_data;
            held_i     = out_idx;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fill(16'h0, 16'h0, 16'h0);
        pack_inputs();
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || done_all !== 1'b0 || out_idx !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: valid=%b done=%b idx=%0d data=%h, need all zero",
                     out_valid, done_all, out_idx, out_data);
        end
        tests_run++;
        if (y !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_y: y nonzero, need zero");
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || done_all !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_start: valid=%b done=%b, need 0 0", out_valid, done_all);
        end
    endtask

    task automatic test_basic();
        fill(16'h0100, 16'h0080, 16'h0000);
        run_stream(0, 1, 200);
        tests_run++;
        if (got_data.size() != OS) begin
            tests_failed++;
            $display("[TB] FAIL basic_count: got %0d transfers, need %0d", got_data.size(), OS);
        end
        tests_run++;
        if (first_valid != 2) begin
            tests_failed++;
            $display("[TB] FAIL basic_first_latency: element 0 after edge %0d, need 2", first_valid);
        end
        tests_run++;
        if (done_cyc != OS + 2) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_latency: done_all after edge %0d, need %0d", done_cyc, OS + 2);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            tests_run++;
            if (got_idx[i] != i || got_data[i] !== 16'h0200) begin
                tests_failed++;
                $display("[TB] FAIL basic_elem[%0d]: idx=%0d data=%h, need idx=%0d data=0200",
                         i, got_idx[i], got_data[i], i);
            end
        end
        for (int j = 0; j < OS; j++) begin
            tests_run++;
            if (y[j*BS +: BS] !== 16'h0200) begin
                tests_failed++;
                $display("[TB] FAIL basic_y[%0d]: got %h, need 0200", j, y[j*BS +: BS]);
            end
        end
    endtask

    task automatic test_relu();
        fill(16'h0000, 16'h0000, 16'hFF00);
        for (int k = 0; k < IS; k++) x_arr[k] = 16'($urandom);
        run_stream(0, 1, 200);
        tests_run++;
        if (got_data.size() != OS || done_cyc < 0) begin
            tests_failed++;
            $display("[TB] FAIL relu_count: got %0d transfers done=%0d, need %0d", got_data.size(), done_cyc, OS);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== 16'h0000 || got_data1[i] !== 16'hFF00) begin
                tests_failed++;
                $display("[TB] FAIL relu_elem[%0d]: relu=%h ident=%h, need 0000 FF00",
                         i, got_data[i], got_data1[i]);
            end
        end
        tests_run++;
        if (y1[45*BS +: BS] !== 16'hFF00 || y[45*BS +: BS] !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL relu_y45: relu=%h ident=%h, need 0000 FF00",
                     y[45*BS +: BS], y1[45*BS +: BS]);
        end
    endtask

    task automatic test_stall();
        fill(16'h0100, 16'h0080, 16'h0000);
        run_stream(1, 1, 400);
        tests_run++;
        if (got_data.size() != OS || done_cyc < 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_count: got %0d transfers done=%0d, need %0d", got_data.size(), done_cyc, OS);
        end
        tests_run++;
        if (hold_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold: %0d stalled cycles changed data/idx, need 0", hold_errs);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            tests_run++;
            if (got_idx[i] != i || got_data[i] !== 16'h0200) begin
                tests_failed++;
                $display("[TB] FAIL stall_elem[%0d]: idx=%0d data=%h, need idx=%0d data=0200",
                         i, got_idx[i], got_data[i], i);
            end
        end
    endtask

    task automatic test_trunc();
        fill(16'h7F00, 16'h7F00, 16'h0000);
        run_stream(0, 1, 200);
        tests_run++;
        if (got_data.size() != OS) begin
            tests_failed++;
            $display("[TB] FAIL trunc_count: got %0d transfers, need %0d", got_data.size(), OS);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== 16'h0400) begin
                tests_failed++;
                $display("[TB] FAIL trunc_elem[%0d]: got %h, need 0400", i, got_data[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_stream(2, 1, 600);
            tests_run++;
            if (got_data.size() != OS || done_cyc < 0) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_count: got %0d transfers done=%0d, need %0d",
                         r, got_data.size(), done_cyc, OS);
            end
            for (int i = 0; i < got_data.size(); i++) begin
                tests_run++;
                if (got_idx[i] != i || got_data[i] !== model(i, 1'b1) || got_data1[i] !== model(i, 1'b0)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand%0d_elem[%0d]: idx=%0d relu=%h ident=%h, need idx=%0d %h %h",
                             r, i, got_idx[i], got_data[i], got_data1[i], i, model(i, 1'b1), model(i, 1'b0));
                end
            end
            for (int j = 0; j < OS; j++) begin
                tests_run++;
                if (y[j*BS +: BS] !== model(j, 1'b1)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand%0d_y[%0d]: got %h, need %h", r, j, y[j*BS +: BS], model(j, 1'b1));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit reached;
        fill_random();
        pack_inputs();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        reached  = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge clk);
            if (out_valid && out_idx == IW'(10)) reached = 1'b1;
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_reach: element 10 not seen, need it within 100 cycles");
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || done_all !== 1'b0 || y !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_clear: valid=%b done=%b y_zero=%b, need 0 0 1",
                     out_valid, done_all, (y == '0));
        end
        @(negedge clk);
        reset = 1'b1;
        fill_random();
        run_stream(0, 0, 200);
        tests_run++;
        if (got_data.size() != OS || first_valid != 2) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_rerun: got %0d transfers first=%0d, need %0d and 2",
                     got_data.size(), first_valid, OS);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            tests_run++;
            if (got_idx[i] != i || got_data[i] !== model(i, 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_elem[%0d]: idx=%0d data=%h, need idx=%0d data=%h",
                         i, got_idx[i], got_data[i], i, model(i, 1'b1));
            end
        end
    endtask

    task automatic test_no_restart();
        logic [BS*OS-1:0] y_prev;
        bit               restarted;
        y_prev    = y;
        restarted = 1'b0;
        fill_random();
        pack_inputs();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid || !done_all) restarted = 1'b1;
        end
        tests_run++;
        if (restarted || y !== y_prev) begin
            tests_failed++;
            $display("[TB] FAIL held_high: restart=%b y_changed=%b, need 0 0", restarted, (y != y_prev));
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_all !== 1'b0 || y !== y_prev) begin
            tests_failed++;
            $display("[TB] FAIL drop_low: done=%b y_changed=%b, need 0 0", done_all, (y != y_prev));
        end
        run_stream(0, 0, 200);
        tests_run++;
        if (got_data.size() != OS || done_cyc != OS + 2) begin
            tests_failed++;
            $display("[TB] FAIL second_run: got %0d transfers done=%0d, need %0d and %0d",
                     got_data.size(), done_cyc, OS, OS + 2);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== model(i, 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL second_elem[%0d]: got %h, need %h", i, got_data[i], model(i, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_stall();
        test_trunc();
        test_random();
        test_reset_mid();
        test_no_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
